// File: rtl/vmem_threshold_unit.sv
// vmem_threshold_unit: 2-stage elastic LIF integrate/threshold/reset stage with spike counter
// clk/rst_n: clock, async active-low reset
// InValid/InReady, NeuronID_In, VmemLeaked, SynInput, RefCount_In: input beat
// Vth, Vreset, RefPeriod: quasi-static neuron parameters (integer volts / steps)
// OutValid/OutReady, NeuronID_Out, VmemNew, RefCount_Out, SpikeOut: write-back beat
// ClearCount, SpikeCount: saturating count of delivered spikes, clear has priority
module vmem_threshold_unit #(
  parameter int INTEGER_WIDTH = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int REFRACTORY_WIDTH = 4,
  parameter int NEURON_ID_WIDTH = 11
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               InValid,
  output logic                               InReady,
  input  logic        [NEURON_ID_WIDTH-1:0]  NeuronID_In,
  input  logic signed [DATA_WIDTH-1:0]       VmemLeaked,
  input  logic signed [DATA_WIDTH-1:0]       SynInput,
  input  logic        [REFRACTORY_WIDTH-1:0] RefCount_In,
  input  logic signed [INTEGER_WIDTH-1:0]    Vth,
  input  logic signed [INTEGER_WIDTH-1:0]    Vreset,
  input  logic        [REFRACTORY_WIDTH-1:0] RefPeriod,
  input  logic                               ClearCount,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic        [NEURON_ID_WIDTH-1:0]  NeuronID_Out,
  output logic signed [DATA_WIDTH-1:0]       VmemNew,
  output logic        [REFRACTORY_WIDTH-1:0] RefCount_Out,
  output logic                               SpikeOut,
  output logic        [15:0]                 SpikeCount
);
  localparam logic [DATA_WIDTH-1:0] vmax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] vmin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic                        s1_valid, s1_refr, s1_adv, fire;
  logic [NEURON_ID_WIDTH-1:0]  s1_id;
  logic signed [DATA_WIDTH-1:0] s1_vsum, sat_sum, vreset_q, vth_q;
  logic [REFRACTORY_WIDTH-1:0] s1_ref1;
  logic [DATA_WIDTH:0]         sum_ext;
  assign vreset_q = {Vreset, {DATA_WIDTH_FRAC{1'b0}}};
  assign vth_q    = {Vth, {DATA_WIDTH_FRAC{1'b0}}};
  // one guard bit: overflow shows up as guard bit differing from the sign bit
  assign sum_ext  = {VmemLeaked[DATA_WIDTH-1], VmemLeaked} + {SynInput[DATA_WIDTH-1], SynInput};
  assign sat_sum  = (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) ? (sum_ext[DATA_WIDTH] ? vmin : vmax)
                                                                   : sum_ext[DATA_WIDTH-1:0];
  assign s1_adv   = !OutValid || OutReady;
  assign InReady  = !s1_valid || s1_adv;
  assign fire     = !s1_refr && (s1_vsum >= vth_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_refr  <= 1'b0;
      s1_id    <= '0;
      s1_vsum  <= '0;
      s1_ref1  <= '0;
    end else if (InReady) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_id    <= NeuronID_In;
        s1_refr  <= RefCount_In != '0;
        s1_vsum  <= (RefCount_In != '0) ? vreset_q : sat_sum;
        s1_ref1  <= (RefCount_In != '0) ? RefCount_In - 1'b1 : '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid     <= 1'b0;
      SpikeOut     <= 1'b0;
      NeuronID_Out <= '0;
      VmemNew      <= '0;
      RefCount_Out <= '0;
    end else if (s1_adv) begin
      OutValid <= s1_valid;
      if (s1_valid) begin
        NeuronID_Out <= s1_id;
        SpikeOut     <= fire;
        VmemNew      <= fire ? vreset_q : s1_vsum;
        RefCount_Out <= fire ? RefPeriod : s1_ref1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) SpikeCount <= '0;
    else if (ClearCount) SpikeCount <= '0;
    else if (OutValid && OutReady && SpikeOut && SpikeCount != 16'hFFFF) SpikeCount <= SpikeCount + 16'd1;
  end
endmodule

// File: tb/tb_vmem_threshold_unit.sv
// tb_vmem_threshold_unit: directed self-checking bench for vmem_threshold_unit
module tb_vmem_threshold_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic InValid, InReady, ClearCount, OutValid, OutReady, SpikeOut;
  logic [10:0] NeuronID_In, NeuronID_Out;
  logic signed [63:0] VmemLeaked, SynInput, VmemNew;
  logic [3:0] RefCount_In, RefPeriod, RefCount_Out;
  logic signed [31:0] Vth, Vreset;
  logic [15:0] SpikeCount;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  vmem_threshold_unit dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady), .NeuronID_In(NeuronID_In),
    .VmemLeaked(VmemLeaked), .SynInput(SynInput), .RefCount_In(RefCount_In), .Vth(Vth),
    .Vreset(Vreset), .RefPeriod(RefPeriod), .ClearCount(ClearCount), .OutValid(OutValid),
    .OutReady(OutReady), .NeuronID_Out(NeuronID_Out), .VmemNew(VmemNew),
    .RefCount_Out(RefCount_Out), .SpikeOut(SpikeOut), .SpikeCount(SpikeCount)
  );
  function automatic logic [63:0] q(input int i);
    return {i, 32'h0};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic single(input logic [10:0] id, input logic [63:0] vl, input logic [63:0] syn, input logic [3:0] rc);
    @(negedge clk);
    NeuronID_In = id; VmemLeaked = vl; SynInput = syn; RefCount_In = rc; InValid = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    chk("lat1_valid", 64'(OutValid), 64'd0);
    @(negedge clk);
    chk("lat2_valid", 64'(OutValid), 64'd1);
    chk("id", 64'(NeuronID_Out), 64'(id));
  endtask
  task automatic chk_out(input string tag, input logic [63:0] v, input logic spk, input logic [3:0] rc);
    chk({tag, "_vmem"}, VmemNew, v);
    chk({tag, "_spike"}, 64'(SpikeOut), 64'(spk));
    chk({tag, "_ref"}, 64'(RefCount_Out), 64'(rc));
  endtask
  initial begin
    int sent, recv, n;
    logic saw_stall;
    InValid = 0; OutReady = 1; ClearCount = 0; NeuronID_In = 0; VmemLeaked = 0; SynInput = 0;
    RefCount_In = 0; Vth = -52; Vreset = -65; RefPeriod = 5;
    #12;
    chk("rst_outvalid", 64'(OutValid), 0);
    chk("rst_spike", 64'(SpikeOut), 0);
    chk("rst_count", 64'(SpikeCount), 0);
    chk("rst_vmem", VmemNew, 0);
    chk("rst_ref", 64'(RefCount_Out), 0);
    chk("rst_id", 64'(NeuronID_Out), 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("rst_inready", 64'(InReady), 1);
    single(1, q(-60), q(5), 0);
    chk_out("integrate", q(-55), 0, 0);
    single(2, q(-55), q(3), 0);
    chk_out("spike", q(-65), 1, 5);
    @(negedge clk);
    chk("count1", 64'(SpikeCount), 1);
    single(3, q(-60), q(100), 3);
    chk_out("refr3", q(-65), 0, 2);
    single(4, q(-60), q(100), 1);
    chk_out("refr1", q(-65), 0, 0);
    single(5, q(-52) - 64'd1, 0, 0);
    chk_out("below_th", q(-52) - 64'd1, 0, 0);
    // positive saturation lands at max, which is at/above a max threshold: wrap would go negative and not fire
    Vth = 32'h7FFF_FFFF;
    single(6, 64'h7FFF_FFFF_0000_0000, q(2), 0);
    chk_out("sat_pos", q(-65), 1, 5);
    Vth = -52;
    single(7, 64'h8000_0000_0000_0000, q(-1), 0);
    chk_out("sat_neg", 64'h8000_0000_0000_0000, 0, 0);
    @(negedge clk);
    chk("count2", 64'(SpikeCount), 2);
    sent = 0; recv = 0; saw_stall = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      @(negedge clk);
      OutReady = !(c >= 3 && c <= 5);
      InValid = sent < 8;
      NeuronID_In = 11'(10 + sent); VmemLeaked = q(-70 - sent); SynInput = q(2 * sent); RefCount_In = 0;
      #1;
      if (!InReady) begin
        saw_stall = 1;
        chk("bp_stall_cond", {62'd0, OutValid, OutReady}, 64'd2);
      end
      if (OutValid && OutReady) begin
        chk("bp_id", 64'(NeuronID_Out), 64'(10 + recv));
        chk("bp_vmem", VmemNew, q(-70 + recv));
        recv++;
      end
      if (InValid && InReady) sent++;
    end
    InValid = 0; OutReady = 1;
    chk("bp_recv", 64'(recv), 8);
    chk("bp_saw_stall", 64'(saw_stall), 1);
    @(negedge clk);
    chk("bp_no_dup", 64'(OutValid), 0);
    chk("bp_count", 64'(SpikeCount), 2);
    n = 65533; sent = 0;
    NeuronID_In = 9; VmemLeaked = q(-55); SynInput = q(3); RefCount_In = 0;
    for (int c = 0; c < 70000 && sent < n; c++) begin
      @(negedge clk);
      InValid = 1;
      #1;
      if (InReady) sent++;
    end
    @(negedge clk);
    InValid = 0;
    repeat (3) @(negedge clk);
    chk("count_ffff", 64'(SpikeCount), 64'hFFFF);
    single(11, q(-55), q(3), 0);
    chk_out("spike_at_max", q(-65), 1, 5);
    @(negedge clk);
    chk("count_hold", 64'(SpikeCount), 64'hFFFF);
    single(12, q(-55), q(3), 0);
    chk("clr_spike", 64'(SpikeOut), 1);
    ClearCount = 1;
    @(negedge clk);
    ClearCount = 0;
    chk("count_clear", 64'(SpikeCount), 0);
    NeuronID_In = 20; VmemLeaked = q(-55); SynInput = q(3); RefCount_In = 0; InValid = 1;
    repeat (2) @(negedge clk);
    InValid = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_outvalid", 64'(OutValid), 0);
    chk("midrst_count", 64'(SpikeCount), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_stale", 64'(OutValid), 0);
    end
    chk("midrst_inready", 64'(InReady), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
